// File: rtl/alu_mdu.sv
// alu_mdu: execution unit combining a single-cycle ALU with an iterative
// multiply/divide engine behind valid/ready handshakes on both sides.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  request handshake; in_ready is the only combinational output
//   op, sign, a, b       request payload, sampled only at the accept edge
//   out_valid/out_ready  result handshake; the result is held until consumed
//   result, result_hi    low/high product, quotient/remainder, or ALU result (hi = 0)
//   zero                 result == 0
//   div_by_zero          held result came from DIV with b == 0
//
// Single-cycle ops register their result at the accept edge. MUL/DIV take
// WIDTH iterations (one bit per cycle) on operand magnitudes, then one FIX
// cycle that applies sign correction and the divide-by-zero override.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W + 1;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_XOR = 5'b00100;
    localparam logic [4:0] OP_NOR = 5'b00101;
    localparam logic [4:0] OP_SLT = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01000;
    localparam logic [4:0] OP_DIV = 5'b01001;
    localparam logic [4:0] OP_SLL = 5'b10000;
    localparam logic [4:0] OP_SRL = 5'b10001;
    localparam logic [4:0] OP_SRA = 5'b10010;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     hi_q, hi_d;        // product high / partial remainder
    logic [WIDTH-1:0]     lo_q, lo_d;        // multiplier / dividend -> quotient
    logic [WIDTH-1:0]     dvs_q, dvs_d;      // multiplicand / divisor magnitude
    logic                 is_div_q, is_div_d;
    logic                 sa_q, sa_d;        // a was negative under signed mode
    logic                 sb_q, sb_d;        // b was negative under signed mode
    logic                 bz_q, bz_d;        // divisor was zero
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic                 zero_q, zero_d;
    logic                 dbz_q, dbz_d;
    logic                 out_valid_q, out_valid_d;

    // ---------------- single-cycle ALU ----------------
    logic [SH_W-1:0]         shamt;
    logic                    lt;
    logic signed [WIDTH-1:0] sra_res;
    logic [WIDTH-1:0]        alu_res;

    assign shamt   = b[SH_W-1:0];
    assign lt      = sign ? ($signed(a) < $signed(b)) : (a < b);
    assign sra_res = $signed(a) >>> shamt;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = sra_res;
            default: alu_res = '0;
        endcase
    end

    // ---------------- iterative datapath ----------------
    logic             is_md, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign is_md = (op == OP_MUL) | (op == OP_DIV);
    assign a_neg = sign & a[WIDTH-1];
    assign b_neg = sign & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Shift-add: add the multiplicand when the multiplier LSB is set, then
    // shift the {carry, hi, lo} pair right by one.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);

    // Restoring division: the partial remainder stays below the divisor, so
    // the difference always fits in WIDTH bits when the subtraction is taken.
    assign div_sh   = {hi_q, lo_q[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, dvs_q};
    assign div_diff = div_sh[WIDTH-1:0] - dvs_q;

    assign prod_fix = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    // b == 0 overrides the quotient; the remainder then naturally equals a.
    assign quo_fix  = bz_q ? '1 : ((sa_q ^ sb_q) ? -lo_q : lo_q);
    assign rem_fix  = sa_q ? -hi_q : hi_q;

    // ---------------- control ----------------
    logic accept;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dvs_d       = dvs_q;
        is_div_d    = is_div_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        bz_d        = bz_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;

        in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
        accept   = in_valid & in_ready;

        case (state_q)
            S_CALC: begin
                if (is_div_q) begin
                    hi_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ge};
                end else begin
                    hi_d = mul_sum[WIDTH:1];
                    lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                end
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    result_d    = quo_fix;
                    result_hi_d = rem_fix;
                    dbz_d       = bz_q;
                end else begin
                    result_d    = prod_fix[WIDTH-1:0];
                    result_hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    dbz_d       = 1'b0;
                end
                zero_d  = (result_d == '0);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            if (is_md) begin
                state_d  = S_CALC;
                count_d  = CNT_W'(WIDTH);
                hi_d     = '0;
                lo_d     = a_mag;
                dvs_d    = b_mag;
                is_div_d = (op == OP_DIV);
                sa_d     = a_neg;
                sb_d     = b_neg;
                bz_d     = (b == '0);
            end else begin
                state_d     = S_DONE;
                result_d    = alu_res;
                result_hi_d = '0;
                dbz_d       = 1'b0;
                zero_d      = (alu_res == '0);
            end
        end

        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            dvs_q       <= '0;
            is_div_q    <= 1'b0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            bz_q        <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dvs_q       <= dvs_d;
            is_div_q    <= is_div_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            bz_q        <= bz_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu (WIDTH = 32). A reference model computes each
// request's outcome with plain arithmetic; a negedge monitor tracks
// outstanding requests in a queue with their due cycle and checks
// out_valid, in_ready and the result fields every cycle.
module tb_alu_mdu;
    localparam int W = 32;

    localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, AND_ = 5'b00010,
                           OR_ = 5'b00011, XOR_ = 5'b00100, NOR_ = 5'b00101,
                           SLT = 5'b00110, MUL = 5'b01000, DIV = 5'b01001,
                           SLL = 5'b10000, SRL = 5'b10001, SRA = 5'b10010;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, sign, out_valid, out_ready;
    logic         zero, div_by_zero;
    logic [4:0]   op;
    logic [W-1:0] a, b, result, result_hi;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .sign(sign), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .result_hi(result_hi),
        .zero(zero), .div_by_zero(div_by_zero)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from the operation definitions.
    function automatic void model(input logic [4:0] o, input logic s,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [31:0] rh,
                                  output logic dz);
        logic [63:0] p;
        logic [4:0]  sh;
        r  = '0;
        rh = '0;
        dz = 1'b0;
        p  = '0;
        sh = y[4:0];
        case (o)
            ADD:  r = x + y;
            SUB:  r = x - y;
            AND_: r = x & y;
            OR_:  r = x | y;
            XOR_: r = x ^ y;
            NOR_: r = ~(x | y);
            SLT: begin
                if (s) r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                else   r = (x < y) ? 32'd1 : 32'd0;
            end
            SLL:  r = x << sh;
            SRL:  r = x >> sh;
            SRA:  r = 32'($signed(x) >>> sh);
            MUL: begin
                if (s) p = 64'(longint'($signed(x)) * longint'($signed(y)));
                else   p = {32'b0, x} * {32'b0, y};
                r  = p[31:0];
                rh = p[63:32];
            end
            DIV: begin
                if (y == 0) begin
                    r = '1; rh = x; dz = 1'b1;
                end else if (s) begin
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                        r = x; rh = '0;
                    end else begin
                        r  = 32'($signed(x) / $signed(y));
                        rh = 32'($signed(x) % $signed(y));
                    end
                end else begin
                    r = x / y; rh = x % y;
                end
            end
            default: r = '0;
        endcase
    endfunction

    typedef struct {
        logic [31:0] r;
        logic [31:0] rh;
        logic        dz;
        int          due;
    } exp_t;

    exp_t q[$];

    // Outstanding-request tracker and per-cycle output checker.
    always @(negedge clk) begin
        exp_t e;
        logic ev, er;
        if (reset) begin
            q.delete();
        end else begin
            ev = (q.size() > 0) && (q[0].due <= cyc);
            er = (q.size() == 0) || (ev && out_ready);
            chk("out_valid", out_valid, ev);
            chk("in_ready", in_ready, er);
            if (out_valid && ev) begin
                chk("result", result, q[0].r);
                chk("result_hi", result_hi, q[0].rh);
                chk("zero", zero, q[0].r == 0);
                chk("div_by_zero", div_by_zero, q[0].dz);
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                model(op, sign, a, b, e.r, e.rh, e.dz);
                e.due = cyc + 1 + (((op == MUL) || (op == DIV)) ? W + 1 : 0);
                q.push_back(e);
            end
        end
    end

    // Present one request and hold it until accepted; scramble the payload
    // afterwards so only the accept-edge values can matter.
    task automatic send(input logic [4:0] o, input logic s, input logic [31:0] x, input logic [31:0] y);
        logic got;
        got = 1'b0;
        op = o; sign = s; a = x; b = y; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept", got, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op   = 5'($urandom);
        sign = 1'($urandom);
        a    = $urandom;
        b    = $urandom;
    endtask

    // Pin the model against a hand-computed value, then drive the request.
    task automatic issue(input logic [4:0] o, input logic s, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic [31:0] erh, input logic edz);
        logic [31:0] mr, mrh;
        logic        mdz;
        model(o, s, x, y, mr, mrh, mdz);
        chk("model_lo", mr, er);
        chk("model_hi", mrh, erh);
        chk("model_dbz", mdz, edz);
        send(o, s, x, y);
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", ok, 1'b1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; sign = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_result_hi", result_hi, 0);
        chk("rst_zero", zero, 1);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // single-cycle sweep, back to back
        issue(ADD, 0, 32'hFFFF_FFFF, 32'd1, 32'h0, 0, 0);
        issue(SUB, 0, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0);
        issue(NOR_, 0, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0);
        issue(SRA, 0, 32'h8000_0000, 32'h21, 32'hC000_0000, 0, 0);
        issue(AND_, 0, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0);
        issue(OR_, 0, 32'hF0, 32'h0F, 32'hFF, 0, 0);
        issue(XOR_, 0, 32'hFF, 32'h0F, 32'hF0, 0, 0);
        issue(SLL, 0, 32'd1, 32'h24, 32'h10, 0, 0);
        issue(SRL, 0, 32'h8000_0000, 32'd31, 32'd1, 0, 0);
        issue(SLT, 1, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0);
        issue(SLT, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0);
        issue(SLT, 1, 32'd7, 32'd7, 32'd0, 0, 0);
        issue(5'b00111, 0, 32'd5, 32'd3, 32'd0, 0, 0);

        // multiply / divide
        issue(MUL, 1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 0);
        issue(MUL, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0);
        issue(MUL, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'd24, 32'd0, 0);
        issue(DIV, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        issue(DIV, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
        issue(DIV, 0, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1);
        issue(DIV, 1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1);
        issue(DIV, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        issue(ADD, 0, 32'd1, 32'd1, 32'd2, 0, 0);
        drain();

        // back-pressure: result held, no new request taken
        out_ready = 1'b0;
        issue(ADD, 0, 32'd10, 32'd20, 32'd30, 0, 0);
        repeat (10) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_result", result, 32'd30);
            chk("hold_result_hi", result_hi, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(ADD, 0, 32'd7, 32'd8, 32'd15, 0, 0);
        @(negedge clk);
        chk("swap_valid", out_valid, 1);
        chk("swap_result", result, 32'd15);
        drain();

        // asynchronous reset in the middle of a divide
        issue(DIV, 0, 32'd1000, 32'd3, 32'd333, 32'd1, 0);
        repeat (11) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_result", result, 0);
        chk("arst_result_hi", result_hi, 0);
        chk("arst_zero", zero, 1);
        chk("arst_dbz", div_by_zero, 0);
        chk("arst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(ADD, 0, 32'd2, 32'd3, 32'd5, 0, 0);
        @(negedge clk);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_result", result, 32'd5);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised multi-cycle execution unit for the processor datapath. It combines the single-cycle ALU operation set with an iterative multiply/divide unit. Operands enter through a valid/ready handshake, and results leave through a second valid/ready handshake. Single-cycle ops complete with 1-cycle latency; multiply and divide take WIDTH+1 cycles. Output registers hold the result stable under back-pressure.

## Interface
- WIDTH, 32, datapath width in bits (≥ 8, power of 2); SH_W = $clog2(WIDTH) is derived.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/op request valid
- in_ready  output  1  unit accepts the request this cycle
- op  input  5  operation code
- sign  input  1  1 = signed interpretation for SLT, MUL, DIV
- a  input  WIDTH  operand 1
- b  input  WIDTH  operand 2
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes the result this cycle
- result  output  WIDTH  ALU result / product low half / quotient
- result_hi  output  WIDTH  product high half / remainder; 0 for single-cycle ops
- zero  output  1  result == 0 (low half only)
- div_by_zero  output  1  the held result came from DIV with b == 0

## Operation
- Op codes:
  - ADD 00000
  - SUB 00001
  - AND 00010
  - OR 00011
  - XOR 00100
  - NOR 00101
  - SLT 00110
  - MUL 01000
  - DIV 01001
  - SLL 10000
  - SRL 10001
  - SRA 10010
  - Any other code: result 0, 1-cycle path.
- ADD/SUB: modulo 2^WIDTH, no overflow flag.
- SLT: result = {0…, a<b}; signed compare when sign = 1, otherwise unsigned.
- Shifts use b[SH_W-1:0] only; upper bits of b are ignored. SRA replicates a[WIDTH-1].
- MUL: full 2·WIDTH-bit product, {result_hi, result}.
  - sign = 1 multiplies the two's-complement operands; sign = 0 multiplies unsigned.
- DIV: quotient in result, remainder in result_hi.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - b == 0: quotient = all ones, remainder = a, div_by_zero = 1. This holds regardless of sign.
  - Signed MIN / -1: quotient = MIN, remainder = 0.
- MUL/DIV algorithm:
  - Magnitudes are taken at accept (|x| when sign = 1 and x is negative).
  - WIDTH iterations of shift-add (MUL) or restoring shift-subtract (DIV), one bit per cycle.
  - The result is negated in FIX where required.
- State machine: IDLE, CALC, FIX, DONE.
  - IDLE + accept of a single-cycle op → DONE; the result is computed and registered at the accept edge.
  - IDLE + accept of MUL/DIV → CALC, with count = WIDTH and operand magnitudes and sign flags latched.
  - CALC: one iteration per cycle and count decrements; at count = 1 → FIX.
  - FIX: sign correction and the div-by-zero override are applied → DONE.
  - DONE: when out_ready, the result is consumed. A simultaneous accept goes to DONE or CALC per the new op; otherwise → IDLE.
- in_ready = (state == IDLE) | (state == DONE & out_ready). It is combinational from state and out_ready.
- a, b, op and sign are sampled only at the accept edge; later changes have no effect.

## Timing
- Reset (asynchronous): state = IDLE; result, result_hi, div_by_zero, count = 0; out_valid = 0.
  - zero = 1 while result = 0.
  - Any in-flight MUL/DIV is discarded; the first request after reset release is accepted normally.
- Accept occurs at an edge where in_valid & in_ready.
- Single-cycle op: out_valid is high from the accept edge + 1 cycle (latency 1). Back-to-back throughput is 1 op/cycle when out_ready is held high.
- MUL/DIV: out_valid rises WIDTH+1 cycles after the accept edge (33 for WIDTH = 32). in_ready stays low during CALC and FIX.
- out_valid is held under back-pressure (out_ready = 0).
  - result, result_hi, zero and div_by_zero stay stable.
  - No new request is accepted.
- out_valid drops on the edge after consumption unless a new single-cycle op was accepted on that same edge.
- All outputs are registered except in_ready.
- zero and div_by_zero are valid only while out_valid = 1.

## Test plan
- WIDTH = 32 sweep:
  - ADD 0xFFFFFFFF+1 → result 0, zero = 1.
  - SUB 5−7 → 0xFFFFFFFE.
  - NOR 0,0 → 0xFFFFFFFF.
  - SRA 0x80000000 by b = 0x21 → 0xC0000000 (shift by 1).
  - Each op → out_valid 1 cycle after accept.
- SLT with a = 0xFFFFFFFF, b = 1: sign = 1 → 1; sign = 0 → 0. Equal operands → 0.
- MUL:
  - sign = 1, −3 × 5 → result 0xFFFFFFF1, result_hi 0xFFFFFFFF, out_valid exactly 33 cycles after accept.
  - sign = 0, 0xFFFFFFFF² → hi 0xFFFFFFFE, lo 0x00000001.
- DIV:
  - sign = 1, −7/2 → q 0xFFFFFFFD, r 0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF signed → q 0x80000000, r 0.
  - 9/0 → q 0xFFFFFFFF, r 9, div_by_zero = 1.
- Handshake:
  - Hold out_ready = 0 for 10 cycles after a result: outputs stay stable and in_ready = 0.
  - Then out_ready = 1 with a new ADD on in_valid: both transfers happen on the same edge, and the next result appears 1 cycle later.
- Assert reset in CALC cycle 12 of a DIV → all outputs at reset values immediately (asynchronous). After release, ADD 2+3 → 5 with latency 1.
